// File: rtl/seq4_pkg.sv
// rtl/seq4_pkg.sv - state codes and detect-set helpers for seq4_detect_ctrl
package seq4_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6,
    S7 = 4'd7,
    S8 = 4'd8
  } state_t;

  // One bit per state code; set bits mark the run-of-four states S4 and S8.
  localparam logic [(1 << ST_W)-1:0] DETECT_MASK = 16'h0110;

  function automatic logic is_detect(input logic [ST_W-1:0] s);
    return DETECT_MASK[s];
  endfunction

endpackage

// File: rtl/seq4_detect_ctrl_sat_counter.sv
// rtl/seq4_detect_ctrl_sat_counter.sv - saturating up-counter, clear beats increment
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seq4_detect_ctrl.sv
// rtl/seq4_detect_ctrl.sv - run-of-four detector FSM with saturating match counter
// Optional Mealy early flag on z_early when SEQ4_MEALY_EN is defined.
module seq4_detect_ctrl
  import seq4_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic [ST_W-1:0]  state,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             z_early
);

  state_t r_state;
  logic   r_z;
  state_t w_next;
  logic   w_inc;

  // Codes 9..15 fall into the default arm and recover to S0 without in_valid.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S0: if (in_valid) w_next = in_bit ? S5 : S1;
      S1: if (in_valid) w_next = in_bit ? S5 : S2;
      S2: if (in_valid) w_next = in_bit ? S5 : S3;
      S3: if (in_valid) w_next = in_bit ? S5 : S4;
      S4: if (in_valid) w_next = in_bit ? S5 : S4;
      S5: if (in_valid) w_next = in_bit ? S6 : S1;
      S6: if (in_valid) w_next = in_bit ? S7 : S1;
      S7: if (in_valid) w_next = in_bit ? S8 : S1;
      S8: if (in_valid) w_next = in_bit ? S8 : S1;
      default: w_next = S0;
    endcase
  end

  assign w_inc = in_valid && is_detect(w_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_z     <= is_detect(w_next);
    end
  end

  assign state = r_state;
  assign z     = r_z;

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clr_cnt),
    .inc  (w_inc),
    .q    (match_cnt)
  );

`ifdef SEQ4_MEALY_EN
  assign z_early = w_inc;
`else
  assign z_early = 1'b0;
`endif

endmodule

// File: tb/tb_seq4_detect_ctrl.sv
// tb/tb_seq4_detect_ctrl.sv - directed bench with run-length reference model for seq4_detect_ctrl
module tb_seq4_detect_ctrl;
  import seq4_pkg::*;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [3:0]       state;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             z_early;

  int n_tests = 0;
  int n_fail  = 0;

  logic chk_en    = 1'b0;
  logic tb_forced = 1'b0;

  // Reference model: the last accepted bit and how many identical bits (capped at 4) end the stream.
  logic m_bit = 1'b0;
  int   m_run = 0;
  int   m_cnt = 0;

  seq4_detect_ctrl #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clr_cnt  (clr_cnt),
    .state    (state),
    .z        (z),
    .match_cnt(match_cnt),
    .z_early  (z_early)
  );

  always #5 clk = ~clk;

  function automatic int next_run();
    if (!in_valid) return m_run;
    if (m_run == 0 || in_bit != m_bit) return 1;
    return (m_run >= 4) ? 4 : m_run + 1;
  endfunction

  function automatic int exp_state();
    if (m_run == 0) return 0;
    return (m_bit ? 4 : 0) + m_run;
  endfunction

  function automatic int exp_z_early();
`ifdef SEQ4_MEALY_EN
    return (in_valid && !tb_forced && next_run() == 4) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 0;
      m_cnt <= 0;
    end else if (tb_forced) begin
      m_run <= 0;
      if (clr_cnt) m_cnt <= 0;
    end else begin
      m_run <= next_run();
      if (in_valid) m_bit <= in_bit;
      if (clr_cnt) m_cnt <= 0;
      else if (in_valid && next_run() == 4 && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !tb_forced) begin
      check("model_state", int'(state), exp_state());
      check("model_z", int'(z), (m_run == 4) ? 1 : 0);
      check("model_cnt", int'(match_cnt), m_cnt);
      check("model_z_early", int'(z_early), exp_z_early());
    end
  end

  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int zero_states[5];
    int brk_bits[8];
    int brk_states[8];
    zero_states = '{1, 2, 3, 4, 4};
    brk_bits    = '{1, 1, 1, 0, 1, 1, 1, 1};
    brk_states  = '{5, 6, 7, 1, 5, 6, 7, 8};

    // Reset then idle
    do_reset(2);
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("idle_state", int'(state), 0);
      check("idle_z", int'(z), 0);
      check("idle_cnt", int'(match_cnt), 0);
    end

    // Zero run of five
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("zero_state", int'(state), zero_states[i]);
      check("zero_z", int'(z), (i >= 3) ? 1 : 0);
    end
    check("zero_cnt", int'(match_cnt), 2);

    // Break in a ones run
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, brk_bits[i][0], 1'b0);
      check("brk_state", int'(state), brk_states[i]);
      check("brk_z", int'(z), (i == 7) ? 1 : 0);
    end
    check("brk_cnt", int'(match_cnt), 1);

    // in_valid gaps inside a run
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("gap_state", int'(state), 5 + i);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("gap_hold", int'(state), 5 + i);
    end
    check("gap_cnt", int'(match_cnt), 1);

    // Saturation then clear racing an increment
    do_reset(1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
    check("sat_cnt", int'(match_cnt), 255);
    step(1'b1, 1'b0, 1'b1);
    check("clr_cnt", int'(match_cnt), 0);
    check("clr_state", int'(state), 4);

    // Reset mid-run loses the partial run
    do_reset(1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("mid_pre", int'(state), 3);
    do_reset(1);
    check("mid_reset", int'(state), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("mid_state", int'(state), 3);
    check("mid_z", int'(z), 0);

    // Illegal code recovers without in_valid
    force dut.r_state = state_t'(4'd12);
    tb_forced = 1'b1;
    #1;
    release dut.r_state;
    step(1'b0, 1'b0, 1'b0);
    tb_forced = 1'b0;
    check("illegal_state", int'(state), 0);
    check("illegal_z", int'(z), 0);
    step(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
